// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit with a small on-chip instruction store.
//
// The store is filled through the load port while the unit is idle. Once
// started, the unit reads the store sequentially and presents one instruction
// at a time to a consumer using a valid/accept handshake. Branch redirects
// flush everything in flight. A fetched all-zero word stops the unit for good
// (until reset).
//
// Optional feature macro: IFU_PREFETCH_EN
//   undefined : single buffer register, next read issued only when the
//               buffered instruction is accepted (one instruction per 2 cycles)
//   defined   : 2-entry prefetch FIFO (one instruction per cycle under
//               continuous accept)
//
// Ports
//   cpu_clk                  clock, all state updates on the rising edge
//   cpu_rst                  synchronous active-high reset
//   run                      start fetching from PC 0 (honoured only when idle)
//   load_valid/addr/data     store write port (honoured only when idle)
//   cpu_accept               consumer takes the presented instruction
//   branch_taken/target      redirect fetch to byte address branch_target
//   cpu_instruction          presented instruction word
//   cpu_instruction_RDY_BSY  1 = cpu_instruction valid, 0 = busy / nothing
//   fetch_pc                 byte address of the presented instruction
//   halted                   fetch stopped on a zero word
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int MEM_DEPTH = 64
) (
    input  logic                         cpu_clk,
    input  logic                         cpu_rst,
    input  logic                         run,
    input  logic                         load_valid,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                  load_data,
    input  logic                         cpu_accept,
    input  logic                         branch_taken,
    input  logic [31:0]                  branch_target,
    output logic [31:0]                  cpu_instruction,
    output logic                         cpu_instruction_RDY_BSY,
    output logic [31:0]                  fetch_pc,
    output logic                         halted
);

    localparam int AW = $clog2(MEM_DEPTH);

`ifdef IFU_PREFETCH_EN
    localparam logic [1:0] BUF_DEPTH = 2'd2;
`else
    localparam logic [1:0] BUF_DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALT} state_t;

    state_t      state;
    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] pc;
    logic [31:0] rd_data;
    logic [31:0] rd_pc;
    logic        rd_valid;
    logic [31:0] buf0_data;
    logic [31:0] buf0_pc;
`ifdef IFU_PREFETCH_EN
    logic [31:0] buf1_data;
    logic [31:0] buf1_pc;
`endif
    logic [1:0]  count;
    logic        halt_pending;
    logic        halted_q;

    logic          pop;
    logic          push;
    logic          zero_hit;
    logic [1:0]    occupancy;
    logic          can_issue;
    logic [AW-1:0] word_idx;
    logic [AW-1:0] next_idx;
    logic [31:0]   pc_next;

    // The two low bits of a branch target are dropped (word alignment).
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];

    // Handshake and read-issue decisions for the coming edge. A read may be
    // issued only when every instruction already buffered or in flight will
    // still have a buffer slot, which throttles the non-prefetch build to one
    // outstanding instruction. A landing zero word blocks further reads.
    always_comb begin
        pop       = 1'b0;
        push      = 1'b0;
        zero_hit  = 1'b0;
        occupancy = 2'd0;
        can_issue = 1'b0;
        word_idx  = pc[AW+1:2];
        next_idx  = word_idx + AW'(1);
        pc_next   = {pc[31:AW+2], next_idx, 2'b00};
        if (state == FETCH) begin
            pop       = (count != 2'd0) && cpu_accept;
            push      = rd_valid && (rd_data != 32'd0);
            zero_hit  = rd_valid && (rd_data == 32'd0);
            occupancy = count + {1'b0, rd_valid} - {1'b0, pop};
            can_issue = !halt_pending && !zero_hit && (occupancy < BUF_DEPTH);
        end
    end

    // Instruction store write port, open only while idle. Not reset so that
    // the program survives a reset.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst && (state == IDLE) && load_valid) begin
            mem[load_addr] <= load_data;
        end
    end

    // Main fetch state machine: PC, synchronous store read, instruction
    // buffer and halt tracking. A branch in FETCH wins over everything else
    // and discards both the buffer and any read in flight.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state        <= IDLE;
            pc           <= 32'd0;
            rd_data      <= 32'd0;
            rd_pc        <= 32'd0;
            rd_valid     <= 1'b0;
            buf0_data    <= 32'd0;
            buf0_pc      <= 32'd0;
`ifdef IFU_PREFETCH_EN
            buf1_data    <= 32'd0;
            buf1_pc      <= 32'd0;
`endif
            count        <= 2'd0;
            halt_pending <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= FETCH;
                        pc    <= 32'd0;
                    end
                end
                FETCH: begin
                    if (branch_taken) begin
                        state        <= FLUSH;
                        pc           <= {branch_target[31:2], 2'b00};
                        count        <= 2'd0;
                        rd_valid     <= 1'b0;
                        halt_pending <= 1'b0;
                    end else begin
`ifdef IFU_PREFETCH_EN
                        // Head is slot 0; a push lands in the first free
                        // slot after this edge's pop.
                        if (pop && (count == 2'd2)) begin
                            buf0_data <= buf1_data;
                            buf0_pc   <= buf1_pc;
                        end
                        if (push) begin
                            if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                                buf0_data <= rd_data;
                                buf0_pc   <= rd_pc;
                            end else begin
                                buf1_data <= rd_data;
                                buf1_pc   <= rd_pc;
                            end
                        end
`else
                        if (push) begin
                            buf0_data <= rd_data;
                            buf0_pc   <= rd_pc;
                        end
`endif
                        count <= count + {1'b0, push} - {1'b0, pop};
                        if (zero_hit) begin
                            halt_pending <= 1'b1;
                        end
                        if (can_issue) begin
                            rd_data  <= mem[word_idx];
                            rd_pc    <= pc;
                            rd_valid <= 1'b1;
                            pc       <= pc_next;
                        end else begin
                            rd_valid <= 1'b0;
                        end
                        if (halt_pending && (count == 2'd0)) begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Single cycle: issue the read of the branch target.
                    rd_data  <= mem[word_idx];
                    rd_pc    <= pc;
                    rd_valid <= 1'b1;
                    pc       <= pc_next;
                    state    <= FETCH;
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_instruction         = buf0_data;
    assign fetch_pc                = buf0_pc;
    assign cpu_instruction_RDY_BSY = (state == FETCH) && (count != 2'd0);
    assign halted                  = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch (default MEM_DEPTH = 64). Directed
// cycle table for start-up latency, hold, branch and accept+branch, hand
// sequences for halt, throughput and reset, and a randomized run checked
// against a program-order model of the instruction stream.
// Compile with +define+IFU_PREFETCH_EN to exercise the prefetch build.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] W0 = 32'h00500093;
    localparam logic [31:0] W1 = 32'h00508113;
    localparam logic [31:0] W2 = 32'h00A00193;
    localparam logic [31:0] W3 = 32'h00B00213;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        run;
    logic        load_valid;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        cpu_accept;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] cpu_instruction;
    logic        cpu_instruction_RDY_BSY;
    logic [31:0] fetch_pc;
    logic        halted;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        run;
        logic        acc;
        logic        br;
        logic [31:0] tgt;
        logic        exp_rdy;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs [19];
    logic [31:0] mem_model [64];

    instr_fetch #(.MEM_DEPTH(64)) dut (
        .cpu_clk                 (cpu_clk),
        .cpu_rst                 (cpu_rst),
        .run                     (run),
        .load_valid              (load_valid),
        .load_addr               (load_addr),
        .load_data               (load_data),
        .cpu_accept              (cpu_accept),
        .branch_taken            (branch_taken),
        .branch_target           (branch_target),
        .cpu_instruction         (cpu_instruction),
        .cpu_instruction_RDY_BSY (cpu_instruction_RDY_BSY),
        .fetch_pc                (fetch_pc),
        .halted                  (halted)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic b,
                                 input logic [31:0] t);
        run           = r;
        cpu_accept    = a;
        branch_taken  = b;
        branch_target = t;
    endtask

    task automatic loadWord(input int addr, input logic [31:0] data);
        load_valid = 1'b1;
        load_addr  = 6'(addr);
        load_data  = data;
        mem_model[addr] = data;
        @(negedge cpu_clk);
        load_valid = 1'b0;
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 32'd0);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
    endtask

    initial begin
        int          k;
        int          first_idx;
        int          ninth_idx;
        int          seen;
        int          bubbles;
        logic [31:0] pc_m;
        logic [31:0] tgt;
        logic        acc;
        logic        br;
        logic        rdy_now;
        logic        prev_rdy;
        logic        prev_acc;
        logic        prev_br;
        logic        saw_wrap;
        logic [31:0] halt_words [3];
        int          exp_gap;

        applyStimulus(0, 0, 0, 32'd0);
        load_valid = 1'b0;
        load_addr  = 6'd0;
        load_data  = 32'd0;
        cpu_rst    = 1'b1;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        checkOutput("reset_instr", cpu_instruction, 32'd0);
        checkOutput("reset_rdy", {31'd0, cpu_instruction_RDY_BSY}, 32'd0);
        checkOutput("reset_pc", fetch_pc, 32'd0);
        checkOutput("reset_halted", {31'd0, halted}, 32'd0);
        cpu_rst = 1'b0;

        // ---------------- directed cycle table ----------------
        loadWord(0, W0);
        loadWord(1, W1);
        loadWord(2, W2);
        loadWord(3, W3);
        for (int i = 4; i < 64; i++) loadWord(i, 32'h1000_0000 | 32'(i));

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
        for (int i = 2; i < 8; i++)
            vecs[i] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, W0, 32'h0};
`ifdef IFU_PREFETCH_EN
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, W1, 32'h4};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, W2, 32'h8};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, W3, 32'hC};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, W3, 32'hC};
`else
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, W1, 32'h4};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, W2, 32'h8};
`endif
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hB,  1'b0, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, W2, 32'h8};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, W1, 32'h4};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, W1, 32'h4};

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].run, vecs[i].acc, vecs[i].br, vecs[i].tgt);
            @(negedge cpu_clk);
            checkOutput($sformatf("vec%0d_rdy", i), {31'd0, cpu_instruction_RDY_BSY},
                        {31'd0, vecs[i].exp_rdy});
            checkOutput($sformatf("vec%0d_halted", i), {31'd0, halted}, 32'd0);
            if (vecs[i].exp_rdy) begin
                checkOutput($sformatf("vec%0d_instr", i), cpu_instruction, vecs[i].exp_instr);
                checkOutput($sformatf("vec%0d_pc", i), fetch_pc, vecs[i].exp_pc);
            end
        end

        // ---------------- halt on zero word ----------------
        doReset();
        halt_words[0] = W0;
        halt_words[1] = W1;
        halt_words[2] = W2;
        loadWord(3, 32'd0);
        k = 0;
        applyStimulus(1, 1, 0, 32'd0);
        for (int c = 0; c < 30; c++) begin
            @(negedge cpu_clk);
            if (cpu_instruction_RDY_BSY) begin
                if (k < 3) begin
                    checkOutput($sformatf("halt_instr%0d", k), cpu_instruction, halt_words[k]);
                    checkOutput($sformatf("halt_pc%0d", k), fetch_pc, 32'(4 * k));
                end
                k++;
            end
            applyStimulus(0, 1, 0, 32'd0);
        end
        checkOutput("halt_presented", 32'(k), 32'd3);
        checkOutput("halt_halted", {31'd0, halted}, 32'd1);
        checkOutput("halt_rdy", {31'd0, cpu_instruction_RDY_BSY}, 32'd0);
        applyStimulus(1, 1, 1, 32'h10);
        for (int c = 0; c < 4; c++) begin
            @(negedge cpu_clk);
            applyStimulus(0, 0, 0, 32'd0);
            checkOutput("halt_sticky", {31'd0, halted}, 32'd1);
            checkOutput("halt_sticky_rdy", {31'd0, cpu_instruction_RDY_BSY}, 32'd0);
        end

        // ---------------- throughput under continuous accept ----------------
        doReset();
        loadWord(3, W3);
        seen      = 0;
        first_idx = 0;
        ninth_idx = 0;
        applyStimulus(1, 1, 0, 32'd0);
        for (int c = 0; c < 60 && seen < 9; c++) begin
            @(negedge cpu_clk);
            if (cpu_instruction_RDY_BSY) begin
                checkOutput($sformatf("tput_pc%0d", seen), fetch_pc, 32'(4 * seen));
                if (seen == 0) first_idx = c;
                seen++;
                if (seen == 9) ninth_idx = c;
            end
            applyStimulus(0, 1, 0, 32'd0);
        end
`ifdef IFU_PREFETCH_EN
        exp_gap = 8;
`else
        exp_gap = 16;
`endif
        checkOutput("tput_presented", 32'(seen), 32'd9);
        if (seen == 9) checkOutput("tput_cycles_for_8", 32'(ninth_idx - first_idx), 32'(exp_gap));

        // ---------------- randomized stream with wrap and branches ----------------
        doReset();
        loadWord(0, W0);
        for (int i = 1; i < 64; i++) loadWord(i, $urandom | 32'h1);
        applyStimulus(1, 0, 0, 32'd0);
        @(negedge cpu_clk);
        applyStimulus(0, 0, 0, 32'd0);
        checkOutput("rand_start_rdy1", {31'd0, cpu_instruction_RDY_BSY}, 32'd0);
        @(negedge cpu_clk);
        checkOutput("rand_start_rdy2", {31'd0, cpu_instruction_RDY_BSY}, 32'd0);
        @(negedge cpu_clk);
        checkOutput("rand_start_rdy3", {31'd0, cpu_instruction_RDY_BSY}, 32'd1);

        pc_m     = 32'd0;
        bubbles  = 0;
        prev_rdy = 1'b0;
        prev_acc = 1'b0;
        prev_br  = 1'b0;
        saw_wrap = 1'b0;
        for (int c = 0; c < 800; c++) begin
            rdy_now = cpu_instruction_RDY_BSY;
            if (rdy_now) begin
                checkOutput("rand_instr", cpu_instruction, mem_model[(pc_m >> 2) % 64]);
                checkOutput("rand_pc", fetch_pc, pc_m);
                bubbles = 0;
            end else begin
                if (prev_rdy && !prev_acc && !prev_br)
                    checkOutput("rand_hold", {31'd0, rdy_now}, 32'd1);
                bubbles++;
                checkOutput("rand_bubble_bound", {31'd0, (bubbles <= 2)}, 32'd1);
            end
            checkOutput("rand_halted", {31'd0, halted}, 32'd0);
            acc = ($urandom_range(0, 9) < 6);
            br  = rdy_now && ($urandom_range(0, 15) == 0);
            tgt = 32'($urandom_range(0, 255));
            applyStimulus(0, acc, br, tgt);
            if (rdy_now && acc) begin
                if (pc_m == 32'hFC) saw_wrap = 1'b1;
                pc_m = (pc_m + 32'd4) % 32'd256;
            end
            if (br) pc_m = tgt & ~32'd3;
            prev_rdy = rdy_now;
            prev_acc = acc;
            prev_br  = br;
            @(negedge cpu_clk);
        end
        checkOutput("rand_wrap_seen", {31'd0, saw_wrap}, 32'd1);

        // ---------------- reset mid-stream ----------------
        applyStimulus(0, 1, 0, 32'd0);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        checkOutput("midrst_instr", cpu_instruction, 32'd0);
        checkOutput("midrst_rdy", {31'd0, cpu_instruction_RDY_BSY}, 32'd0);
        checkOutput("midrst_pc", fetch_pc, 32'd0);
        checkOutput("midrst_halted", {31'd0, halted}, 32'd0);
        applyStimulus(1, 0, 0, 32'd0);
        @(negedge cpu_clk);
        applyStimulus(0, 0, 0, 32'd0);
        @(negedge cpu_clk);
        checkOutput("rerun_rdy_early", {31'd0, cpu_instruction_RDY_BSY}, 32'd0);
        @(negedge cpu_clk);
        checkOutput("rerun_rdy", {31'd0, cpu_instruction_RDY_BSY}, 32'd1);
        checkOutput("rerun_instr", cpu_instruction, W0);
        checkOutput("rerun_pc", fetch_pc, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter MEM_DEPTH, default 64, SHALL give the number of 32-bit words in the instruction store (power of two, 4..256).
REQ-002 cpu_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 cpu_rst  in  1  reset, SHALL be synchronous and active-high.
REQ-004 run  in  1  start fetching from PC 0 when sampled high in IDLE.
REQ-005 load_valid  in  1  write load_data into the store at load_addr.
REQ-006 load_addr  in  log2(MEM_DEPTH)  word index for the load.
REQ-007 load_data  in  32  instruction word to store.
REQ-008 cpu_accept  in  1  consumer takes the presented instruction this cycle.
REQ-009 branch_taken  in  1  redirect fetch this cycle.
REQ-010 branch_target  in  32  byte address of the redirect.
REQ-011 cpu_instruction  out  32  presented instruction word.
REQ-012 cpu_instruction_RDY_BSY  out  1  1 = cpu_instruction valid, 0 = busy/none.
REQ-013 fetch_pc  out  32  byte address of the presented instruction.
REQ-014 halted  out  1  fetch stopped on a zero word.

Function
REQ-015 States SHALL be IDLE, FETCH, FLUSH, HALT.
REQ-016 IDLE: load_valid SHALL write the store; the write SHALL be ignored in every other state.
REQ-017 IDLE->FETCH SHALL occur on run=1; PC SHALL be set to 0.
REQ-018 Store read SHALL be synchronous, one-cycle latency; the first instruction SHALL be presented with RDY_BSY=1 two cycles after run is sampled high.
REQ-019 PC SHALL be a byte address incremented by 4 per fetched word; the word index SHALL be PC[log2(MEM_DEPTH)+1:2], wrapping from the last word to word 0.
REQ-020 While RDY_BSY=1 and cpu_accept=0, cpu_instruction and fetch_pc SHALL hold stable.
REQ-021 cpu_accept with RDY_BSY=0 SHALL be ignored.
REQ-022 branch_taken in FETCH SHALL enter FLUSH: the buffer is discarded, RDY_BSY=0 on the next cycle, PC = {branch_target[31:2],2'b00}, and the target instruction is presented two cycles after branch_taken; FLUSH->FETCH after one cycle.
REQ-023 branch_taken and cpu_accept in the same cycle: the accept SHALL complete, then the branch SHALL flush as in REQ-022.
REQ-024 branch_taken in IDLE, FLUSH, or HALT SHALL be ignored.
REQ-025 A fetched word of 32'h00000000 SHALL NOT be presented; the block SHALL enter HALT with halted=1 and RDY_BSY=0 once all prior buffered instructions are accepted.
REQ-026 HALT SHALL be left only by reset.
REQ-027 run while in FETCH, FLUSH, or HALT SHALL be ignored.

Reset
REQ-028 On cpu_rst: state=IDLE, PC=0, buffer empty, cpu_instruction=0, RDY_BSY=0, fetch_pc=0, halted=0.
REQ-029 Reset mid-fetch or mid-flush SHALL abandon outstanding reads; the store contents SHALL be preserved.

Configuration
REQ-030 With IFU_PREFETCH_EN defined, a 2-entry prefetch FIFO SHALL allow one instruction presented per cycle under continuous cpu_accept=1.
REQ-031 Without IFU_PREFETCH_EN, the block SHALL hold a single buffer register and issue the next read only after accept, giving at most one instruction every 2 cycles; REQ-018 and REQ-022 latencies SHALL be unchanged.

Verification
REQ-032 Load word0=0x00500093 and word1=0x00508113, then run, with cpu_accept=1 -> 0x00500093 at fetch_pc 0 two cycles after run, then 0x00508113 at fetch_pc 4.
REQ-033 Present word0, hold cpu_accept=0 for 5 cycles -> cpu_instruction=0x00500093 and RDY_BSY=1 stable throughout.
REQ-034 Assert branch_taken with branch_target=0x0000000B at word 2 -> RDY_BSY=0 the next cycle, then fetch_pc=0x8 presented two cycles after the branch.
REQ-035 Load words 0..2 nonzero and word3=0 -> 3 instructions presented, then halted=1 and RDY_BSY=0; a later branch_taken changes nothing.
REQ-036 Load all 64 words nonzero, run -> after fetch_pc 0xFC, fetch_pc wraps to 0x0; assert cpu_rst mid-stream -> all outputs 0 next cycle and a new run refetches 0x00500093.
REQ-037 With IFU_PREFETCH_EN and continuous accept -> 8 instructions in 8 consecutive cycles; without the macro -> the same 8 take 16 cycles.
